// File: rtl/aibcr3_dcc_cal_ctl_if.sv
// Calibration controller bus: control levels and phase-detector results in,
// trial pulses, lock and delay code out.
//   cal_en    start (rising level) / abort (low)
//   track_en  enable +/-1 tracking trials while locked
//   t_up      phase detector: delay too short (asynchronous)
//   t_down    phase detector: delay too long (asynchronous)
//   launch    one-cycle trial start pulse
//   measure   one-cycle phase detector arm pulse
//   i_gray    Gray coded coarse code (cal_code[10:8])
//   f_gray    Gray coded fine code (cal_code[7:0])
//   dll_lock  high once SAR has converged, through tracking trials
//   cal_code  binary delay code (observe)
interface aibcr3_dcc_cal_ctl_if;
  logic        cal_en;
  logic        track_en;
  logic        t_up;
  logic        t_down;
  logic        launch;
  logic        measure;
  logic [2:0]  i_gray;
  logic [7:0]  f_gray;
  logic        dll_lock;
  logic [10:0] cal_code;

  modport master (
    output cal_en, track_en, t_up, t_down,
    input  launch, measure, i_gray, f_gray, dll_lock, cal_code
  );

  modport slave (
    input  cal_en, track_en, t_up, t_down,
    output launch, measure, i_gray, f_gray, dll_lock, cal_code
  );
endinterface

// File: rtl/aibcr3_dcc_cal_ctl.sv
// DCC/DLL calibration controller. Runs an 11-bit SAR search of the delay code
// against a phase detector, then optionally tracks by +/-1 per trial.
// A trial is LAUNCH, MEAS, SETTLE_CYC cycles of SETTLE, then a decision.
//   clk_dcd    calibration clock (rising edge)
//   dll_reset  synchronous active-high reset
//   bus        aibcr3_dcc_cal_ctl_if.slave (controls, detector in; code out)
module aibcr3_dcc_cal_ctl #(
  parameter int SETTLE_CYC = 8  // 2..255
) (
  input  logic                       clk_dcd,
  input  logic                       dll_reset,
  aibcr3_dcc_cal_ctl_if.slave        bus
);

  localparam logic [7:0]  SETTLE_LAST = 8'(SETTLE_CYC - 1);
  localparam logic [10:0] CODE_MID    = 11'h400;
  localparam logic [10:0] CODE_MAX    = 11'h7ff;

  typedef enum logic [2:0] {
    IDLE, LAUNCH, MEAS, SETTLE, DECIDE, LOCKED, TDECIDE
  } state_t;

  state_t      state, state_nx;
  logic [10:0] code, code_nx;
  logic [3:0]  k, k_nx;
  logic [3:0]  k_m1;
  logic [7:0]  cnt, cnt_nx;
  logic        locked, locked_nx;
  logic [1:0]  up_sync, dn_sync;
  logic        up_s, dn_s;

  assign up_s = up_sync[1];
  assign dn_s = dn_sync[1];
  assign k_m1 = k - 4'd1;

  always_ff @(posedge clk_dcd) begin
    if (dll_reset) begin
      state   <= IDLE;
      code    <= '0;
      k       <= 4'd10;
      cnt     <= '0;
      locked  <= 1'b0;
      up_sync <= '0;
      dn_sync <= '0;
    end else begin
      state   <= state_nx;
      code    <= code_nx;
      k       <= k_nx;
      cnt     <= cnt_nx;
      locked  <= locked_nx;
      up_sync <= {up_sync[0], bus.t_up};
      dn_sync <= {dn_sync[0], bus.t_down};
    end
  end

  always_comb begin
    state_nx  = state;
    code_nx   = code;
    k_nx      = k;
    cnt_nx    = cnt;
    locked_nx = locked;
    // Abort wins over any in-flight decision so the code is left untouched.
    if (state != IDLE && !bus.cal_en) begin
      state_nx  = IDLE;
      locked_nx = 1'b0;
      cnt_nx    = '0;
    end else begin
      case (state)
        IDLE: if (bus.cal_en) begin
          code_nx   = CODE_MID;
          k_nx      = 4'd10;
          locked_nx = 1'b0;
          state_nx  = LAUNCH;
        end
        LAUNCH: state_nx = MEAS;
        MEAS: begin
          cnt_nx   = '0;
          state_nx = SETTLE;
        end
        SETTLE: begin
          if (cnt == SETTLE_LAST) begin
            cnt_nx   = '0;
            // The lock flag steers a trial to the tracking decision.
            state_nx = locked ? TDECIDE : DECIDE;
          end else begin
            cnt_nx = cnt + 8'd1;
          end
        end
        DECIDE: begin
          // Both detector outputs high is treated as "too long".
          if (dn_s) code_nx[k] = 1'b0;
          if (k != 4'd0) begin
            k_nx          = k_m1;
            code_nx[k_m1] = 1'b1;
            state_nx      = LAUNCH;
          end else begin
            locked_nx = 1'b1;
            state_nx  = LOCKED;
          end
        end
        LOCKED: if (bus.track_en) state_nx = LAUNCH;
        TDECIDE: begin
          if (up_s && !dn_s && code != CODE_MAX) code_nx = code + 11'd1;
          else if (dn_s && !up_s && code != 11'd0) code_nx = code - 11'd1;
          state_nx = LOCKED;
        end
        default: state_nx = IDLE;
      endcase
    end
  end

  // Outputs come straight from registers; lock flag is set on entry to
  // LOCKED so dll_lock covers tracking trials too.
  assign bus.launch   = (state == LAUNCH);
  assign bus.measure  = (state == MEAS);
  assign bus.dll_lock = locked;
  assign bus.cal_code = code;
  assign bus.i_gray   = code[10:8] ^ (code[10:8] >> 1);
  assign bus.f_gray   = code[7:0] ^ (code[7:0] >> 1);

endmodule

// File: tb/tb_aibcr3_dcc_cal_ctl.sv
module tb_aibcr3_dcc_cal_ctl;
  localparam int S        = 8;
  localparam int TRIAL    = S + 3;
  localparam int LOCK_CYC = 11 * TRIAL + 1;

  logic clk_dcd   = 1'b0;
  logic dll_reset = 1'b1;
  always #5 clk_dcd = ~clk_dcd;

  aibcr3_dcc_cal_ctl_if bus();

  aibcr3_dcc_cal_ctl #(.SETTLE_CYC(S)) dut (
    .clk_dcd  (clk_dcd),
    .dll_reset(dll_reset),
    .bus      (bus.slave)
  );

  int errors = 0;
  int checks = 0;
  // detector modes: 0 compare to target, 1 up stuck, 2 down stuck, 3 both stuck
  int det_mode = 0;
  int target   = 0;

  // Behavioural phase detector: result refreshed after each measure pulse.
  always @(negedge clk_dcd) begin
    if (bus.measure) begin
      case (det_mode)
        0: begin
          bus.t_up   = (int'(bus.cal_code) < target);
          bus.t_down = (int'(bus.cal_code) > target);
        end
        1: begin bus.t_up = 1'b1; bus.t_down = 1'b0; end
        2: begin bus.t_up = 1'b0; bus.t_down = 1'b1; end
        default: begin bus.t_up = 1'b1; bus.t_down = 1'b1; end
      endcase
    end
  end

  function automatic logic [10:0] gray_of(input int v);
    logic [10:0] b, g;
    b = 11'(v);
    g = '0;
    for (int i = 0; i < 11; i++) begin
      if (i == 10 || i == 7) g[i] = b[i];
      else                   g[i] = b[i] ^ b[i+1];
    end
    return g;
  endfunction

  task automatic cyc1();
    @(posedge clk_dcd);
    @(negedge clk_dcd);
  endtask

  task automatic go_idle();
    bus.cal_en   = 1'b0;
    bus.track_en = 1'b0;
    repeat (3) cyc1();
  endtask

  // Full SAR from IDLE; expects convergence to exp_code with standard timing.
  task automatic run_sar(input int exp_code, input string nm);
    int cyc, nl, lock_cyc, overlap;
    logic [10:0] g;
    go_idle();
    bus.cal_en = 1'b1;
    cyc = 0; nl = 0; lock_cyc = 0; overlap = 0;
    while (lock_cyc == 0 && cyc < 400) begin
      cyc1();
      cyc++;
      if (bus.launch) nl++;
      if (bus.launch && bus.measure) overlap++;
      if (cyc == 1) begin
        checks++;
        if (bus.launch !== 1'b1 || bus.cal_code !== 11'h400)
          begin errors++; $display("FAIL %s_start launch=%b code=%h need 1/400", nm, bus.launch, bus.cal_code); end
      end
      if (cyc == 2) begin
        checks++;
        if (bus.measure !== 1'b1)
          begin errors++; $display("FAIL %s_measure got %b need 1", nm, bus.measure); end
      end
      if (bus.dll_lock === 1'b1) lock_cyc = cyc;
    end
    checks++;
    if (lock_cyc != LOCK_CYC)
      begin errors++; $display("FAIL %s_lock_cycle got %0d need %0d", nm, lock_cyc, LOCK_CYC); end
    checks++;
    if (nl != 11) begin errors++; $display("FAIL %s_launches got %0d need 11", nm, nl); end
    checks++;
    if (overlap != 0) begin errors++; $display("FAIL %s_overlap got %0d need 0", nm, overlap); end
    checks++;
    if (int'(bus.cal_code) != exp_code)
      begin errors++; $display("FAIL %s_code got %0d need %0d", nm, bus.cal_code, exp_code); end
    g = gray_of(exp_code);
    checks++;
    if (bus.i_gray !== g[10:8] || bus.f_gray !== g[7:0])
      begin errors++; $display("FAIL %s_gray got %b/%h need %b/%h", nm, bus.i_gray, bus.f_gray, g[10:8], g[7:0]); end
  endtask

  // Tracking trials from LOCKED at start code; model moves by the detector rule.
  task automatic run_track(input int start, input int ntr, input string nm);
    int model, wt, lock_drop;
    bit seen;
    model = start;
    lock_drop = 0;
    bus.track_en = 1'b1;
    for (int t = 0; t < ntr; t++) begin
      seen = 0;
      wt = 0;
      while (!seen && wt < 40) begin
        cyc1();
        wt++;
        if (bus.dll_lock !== 1'b1) lock_drop++;
        if (bus.launch === 1'b1) seen = 1;
      end
      if (!seen) begin
        checks++; errors++;
        $display("FAIL %s_trial_timeout trial=%0d got no launch need launch", nm, t);
        break;
      end
      repeat (TRIAL) begin
        cyc1();
        if (bus.dll_lock !== 1'b1) lock_drop++;
      end
      case (det_mode)
        0: if (model < target) model++; else if (model > target) model--;
        1: if (model < 2047) model++;
        2: if (model > 0) model--;
        default: ;
      endcase
      checks++;
      if (int'(bus.cal_code) != model)
        begin errors++; $display("FAIL %s_trial%0d got %0d need %0d", nm, t, bus.cal_code, model); end
    end
    bus.track_en = 1'b0;
    checks++;
    if (lock_drop != 0) begin errors++; $display("FAIL %s_lock_held drops=%0d need 0", nm, lock_drop); end
  endtask

  task automatic test_reset();
    checks++;
    if ({bus.launch, bus.measure, bus.dll_lock, bus.i_gray, bus.f_gray, bus.cal_code} !== '0)
      begin errors++; $display("FAIL reset_init got %b/%b/%b/%h/%h/%h need all 0", bus.launch, bus.measure, bus.dll_lock, bus.i_gray, bus.f_gray, bus.cal_code); end
    dll_reset = 1'b0;
    det_mode = 0;
    target = int'($urandom_range(0, 2047));
    go_idle();
    bus.cal_en = 1'b1;
    repeat (5) cyc1();
    dll_reset  = 1'b1;
    bus.cal_en = 1'($urandom_range(0, 1));
    bus.t_up   = 1'($urandom_range(0, 1));
    bus.t_down = 1'($urandom_range(0, 1));
    cyc1();
    checks++;
    if ({bus.launch, bus.measure, bus.dll_lock, bus.i_gray, bus.f_gray, bus.cal_code} !== '0)
      begin errors++; $display("FAIL reset_mid got %b/%b/%b/%h/%h/%h need all 0", bus.launch, bus.measure, bus.dll_lock, bus.i_gray, bus.f_gray, bus.cal_code); end
    bus.cal_en = 1'b1;
    cyc1();
    checks++;
    if (bus.launch !== 1'b0 || bus.cal_code !== 11'd0)
      begin errors++; $display("FAIL reset_hold launch=%b code=%h need 0/0", bus.launch, bus.cal_code); end
    dll_reset = 1'b0;
    cyc1();
    checks++;
    if (bus.launch !== 1'b1 || bus.cal_code !== 11'h400)
      begin errors++; $display("FAIL reset_restart launch=%b code=%h need 1/400", bus.launch, bus.cal_code); end
    cyc1();
    checks++;
    if (bus.measure !== 1'b1 || bus.launch !== 1'b0)
      begin errors++; $display("FAIL reset_restart_meas meas=%b launch=%b need 1/0", bus.measure, bus.launch); end
    go_idle();
  endtask

  task automatic test_sar();
    det_mode = 0;
    target = 1234;
    run_sar(1234, "sar1234");
    checks++;
    if (bus.i_gray !== 3'b110 || bus.f_gray !== 8'hbb)
      begin errors++; $display("FAIL sar1234_gray_const got %b/%h need 110/bb", bus.i_gray, bus.f_gray); end
  endtask

  task automatic test_tracking();
    target = 1240;
    run_track(1234, 9, "track1240");
  endtask

  task automatic test_random_sar();
    for (int i = 0; i < 3; i++) begin
      det_mode = 0;
      target = int'($urandom_range(0, 2047));
      run_sar(target, $sformatf("rand%0d", i));
    end
    det_mode = 3;
    run_track(target, 3, "rand_both_hold");
  endtask

  task automatic test_saturation();
    det_mode = 1;
    run_sar(2047, "sat_hi");
    run_track(2047, 3, "sat_hi_trk");
    det_mode = 2;
    run_sar(0, "sat_lo");
    run_track(0, 3, "sat_lo_trk");
  endtask

  task automatic test_both();
    det_mode = 3;
    run_sar(0, "both");
    run_track(0, 2, "both_trk");
  endtask

  task automatic test_abort();
    int cyc, pulses, part;
    det_mode = 0;
    target = int'($urandom_range(0, 2047));
    part = ((target >> 6) << 6) | 32;
    go_idle();
    bus.cal_en = 1'b1;
    cyc = 0;
    while (cyc < 5 * TRIAL + 1) begin cyc1(); cyc++; end
    bus.cal_en = 1'b0;
    cyc1();
    checks++;
    if (bus.dll_lock !== 1'b0 || bus.launch !== 1'b0 || bus.measure !== 1'b0)
      begin errors++; $display("FAIL abort_idle lock=%b launch=%b meas=%b need 0/0/0", bus.dll_lock, bus.launch, bus.measure); end
    checks++;
    if (int'(bus.cal_code) != part)
      begin errors++; $display("FAIL abort_code got %0d need %0d", bus.cal_code, part); end
    pulses = 0;
    repeat (20) begin
      cyc1();
      if (bus.launch || bus.measure || bus.dll_lock) pulses++;
    end
    checks++;
    if (pulses != 0 || int'(bus.cal_code) != part)
      begin errors++; $display("FAIL abort_quiet pulses=%0d code=%0d need 0/%0d", pulses, bus.cal_code, part); end
    run_sar(target, "abort_rerun");
  endtask

  initial begin
    bus.cal_en   = 1'b0;
    bus.track_en = 1'b0;
    bus.t_up     = 1'b0;
    bus.t_down   = 1'b0;
    repeat (3) cyc1();
    test_reset();
    test_sar();
    test_tracking();
    test_saturation();
    test_both();
    test_random_sar();
    test_abort();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
